// File: rtl/des_round_ctrl.sv
// Sequencing FSM for the iterative DES core. It runs one Feistel round per clock,
// drives the L/R and C/D load/enable strobes and the per-round key-schedule shift.
module des_round_ctrl #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       decrypt,
    input  logic       abort,
    output logic       load,
    output logic       round_en,
    output logic [4:0] round,
    output logic [1:0] shift_amt,
    output logic       shift_right,
    output logic       final_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    generate
        if (ROUNDS < 1 || ROUNDS > 16) begin : g_rounds_check
            $error("des_round_ctrl: ROUNDS must be in 1..16");
        end
    endgenerate

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] round_q, round_nxt;
    logic       mode, mode_nxt;

    // Decrypt applies no rotation in round 1 so that round 1 uses K16 (C0/D0 = C16/D16).
    function automatic logic [1:0] shift_for(input logic [4:0] r, input logic dec);
        if (r == 5'd1)
            return dec ? 2'd0 : 2'd1;
        else if (r == 5'd2 || r == 5'd9 || r == 5'd16)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            round_q <= '0;
            mode    <= 1'b0;
        end else begin
            state   <= state_nxt;
            round_q <= round_nxt;
            mode    <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round_q;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = LOAD;
                    mode_nxt  = decrypt;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ROUND;
                    round_nxt = 5'd1;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_nxt = IDLE;
                    round_nxt = '0;
                end else if (round_q == LAST_ROUND) begin
                    state_nxt = FINAL;
                    round_nxt = '0;
                end else begin
                    round_nxt = round_q + 5'd1;
                end
            end
            FINAL: begin
                state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                if (abort || out_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = '0;
            end
        endcase
    end

    // Outputs depend only on registered state, counter and mode.
    always_comb begin
        in_ready    = 1'b0;
        load        = 1'b0;
        round_en    = 1'b0;
        final_en    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        round       = '0;
        shift_amt   = '0;
        shift_right = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            ROUND: begin
                round_en    = 1'b1;
                busy        = 1'b1;
                round       = round_q;
                shift_amt   = shift_for(round_q, mode);
                shift_right = mode;
            end
            FINAL: begin
                final_en = 1'b1;
                busy     = 1'b1;
            end
            DONE:  out_valid = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: per-cycle strobe scoreboard plus a behavioural DES
// datapath driven by the controller strobes to confirm the key-schedule shifts.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       decrypt;
    logic       abort;
    logic       load;
    logic       round_en;
    logic [4:0] round;
    logic [1:0] shift_amt;
    logic       shift_right;
    logic       final_en;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    always #5 clk = ~clk;

    des_round_ctrl #(.ROUNDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .decrypt    (decrypt),
        .abort      (abort),
        .load       (load),
        .round_en   (round_en),
        .round      (round),
        .shift_amt  (shift_amt),
        .shift_right(shift_right),
        .final_en   (final_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef logic [13:0] obs_t;
    obs_t        exp_q[$];
    string       tag_q[$];
    logic [63:0] res_q[$];

    localparam int ENC_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int DEC_T [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // ---------------- behavioural DES datapath ----------------
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                                12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] f_ip(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = v[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = v[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] v);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = v[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] v);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = v[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        int          v;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            v   = SBOX[b*64 + int'({six[5], six[0]})*16 + int'(six[4:1])];
            s[31-4*b -: 4] = v[3:0];
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [27:0] f_rot(input logic [27:0] v, input logic [1:0] amt,
                                          input logic right);
        logic [27:0] o;
        o = v;
        for (int i = 0; i < int'(amt); i++)
            o = right ? {o[0], o[27:1]} : {o[26:0], o[27]};
        return o;
    endfunction

    logic [63:0] blk, key, dout;
    logic [31:0] dp_l, dp_r;
    logic [27:0] dp_c, dp_d, c_nxt, d_nxt;

    always_comb begin
        c_nxt = f_rot(dp_c, shift_amt, shift_right);
        d_nxt = f_rot(dp_d, shift_amt, shift_right);
    end

    always @(posedge clk) begin
        if (load) begin
            {dp_l, dp_r} <= f_ip(blk);
            {dp_c, dp_d} <= f_pc1(key);
        end else if (round_en) begin
            dp_l <= dp_r;
            dp_r <= dp_l ^ f_func(dp_r, f_pc2({c_nxt, d_nxt}));
            dp_c <= c_nxt;
            dp_d <= d_nxt;
        end else if (final_en) begin
            dout <= f_fp({dp_r, dp_l});
        end
    end

    // ---------------- scoreboard ----------------
    // {in_ready, load, round_en, final_en, out_valid, busy, round, shift_amt, shift_right}
    function automatic obs_t mk(input logic ir, input logic ld, input logic re, input logic fe,
                                input logic ov, input logic bz, input logic [4:0] r,
                                input logic [1:0] sa, input logic sr);
        return {ir, ld, re, fe, ov, bz, r, sa, sr};
    endfunction

    task automatic push(input obs_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic exp_idle(input string t);  push(mk(1,0,0,0,0,0,5'd0,2'd0,0), t); endtask
    task automatic exp_load(input string t);  push(mk(0,1,0,0,0,1,5'd0,2'd0,0), t); endtask
    task automatic exp_final(input string t); push(mk(0,0,0,1,0,1,5'd0,2'd0,0), t); endtask
    task automatic exp_done(input string t);  push(mk(0,0,0,0,1,0,5'd0,2'd0,0), t); endtask
    task automatic exp_round(input int r, input logic m, input string t);
        logic [1:0] sa;
        sa = m ? 2'(DEC_T[r-1]) : 2'(ENC_T[r-1]);
        push(mk(0,0,1,0,0,1,5'(r),sa,m), t);
    endtask

    task automatic compare();
        obs_t  e, o;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = {in_ready, load, round_en, final_en, out_valid, busy, round, shift_amt, shift_right};
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, o, e);
            end
        end
        checks++;
        assert ($onehot0({load, round_en, final_en})) else begin
            errors++;
            $error("FAIL strobe_onehot observed=%b expected=onehot0", {load, round_en, final_en});
        end
    endtask

    task automatic check_result();
        logic [63:0] e;
        checks++;
        if (res_q.size() == 0) begin
            errors++;
            $error("FAIL result_queue_empty observed=%h expected=entry", dout);
        end else begin
            e = res_q.pop_front();
            assert (dout === e) else begin
                errors++;
                $error("FAIL des_result observed=%h expected=%h", dout, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic dec, input logic [63:0] b, input logic [63:0] k,
                             input logic [63:0] expect_out, input int hold, input int abort_at,
                             input int rst_at, input bit toggle, input bit abort_done);
        blk      = b;
        key      = k;
        in_valid = 1'b1;
        decrypt  = dec;
        exp_idle("accept");
        tick();
        in_valid = 1'b0;
        if (toggle) decrypt = ~dec;
        if (abort_at == 0 && rst_at == 0) res_q.push_back(expect_out);
        exp_load("load");
        tick();
        for (int r = 1; r <= 16; r++) begin
            if (toggle) begin
                decrypt  = 1'($urandom);
                in_valid = 1'($urandom);
            end
            if (r == rst_at) begin
                exp_round(r, dec, "pre_reset_round");
                @(negedge clk);
                compare();
                #1 rst = 1'b1;
                #1;
                exp_idle("async_reset");
                compare();
                @(posedge clk);
                #1 rst = 1'b0;
                exp_idle("post_reset");
                tick();
                return;
            end
            if (r == abort_at) abort = 1'b1;
            exp_round(r, dec, "round");
            tick();
            if (r == abort_at) begin
                abort = 1'b0;
                exp_idle("after_abort");
                tick();
                return;
            end
        end
        in_valid = 1'b0;
        decrypt  = dec;
        exp_final("final");
        tick();
        check_result();
        out_ready = 1'b0;
        if (hold > 0) in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            exp_done("done_hold");
            tick();
        end
        if (abort_done) abort = 1'b1;
        else            out_ready = 1'b1;
        exp_done("done_release");
        tick();
        out_ready = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        exp_idle("idle_after_done");
        tick();
    endtask

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        decrypt   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        blk       = '0;
        key       = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_idle("reset_state");
        compare();
        rst = 1'b0;
        exp_idle("idle_after_reset");
        tick();

        run_block(1'b0, PT, KEY, CT, 0, 0, 0, 1'b0, 1'b0);   // encrypt
        run_block(1'b1, CT, KEY, PT, 0, 0, 0, 1'b0, 1'b0);   // decrypt
        run_block(1'b0, PT, KEY, CT, 10, 0, 0, 1'b0, 1'b0);  // back-pressure
        run_block(1'b0, PT, KEY, CT, 0, 7, 0, 1'b0, 1'b0);   // abort at round 7
        run_block(1'b1, CT, KEY, PT, 0, 0, 0, 1'b0, 1'b0);
        run_block(1'b0, PT, KEY, CT, 0, 0, 9, 1'b0, 1'b0);   // async reset at round 9
        run_block(1'b0, PT, KEY, CT, 0, 0, 0, 1'b0, 1'b0);
        run_block(1'b1, CT, KEY, PT, 0, 0, 0, 1'b1, 1'b0);   // input toggling mid-run
        run_block(1'b0, PT, KEY, CT, 2, 0, 0, 1'b0, 1'b1);   // abort in DONE
        run_block(1'b0, PT, KEY, CT, 0, 0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
